spi_embed_loader: RTL and testbench

//  SPI-slave-to-bus bridge used in embedded boot mode: external host streams address/data frames

---
 rtl/spi_embed_loader.sv | 134 +++++++++++++
 tb/tb_spi_embed_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_embed_loader.sv
// spi_embed_loader: SPI-slave frame decoder that issues single bus writes/reads.
// Ports: i_clk/i_rst_n; i_spi_clk/i_spi_mosi async pads, o_spi_miso busy/read data;
//   o_bus_req/we/addr/data request held until i_bus_ack; i_bus_data read data.
module spi_embed_loader #(
   parameter int AW   = 24,
   parameter int DW   = 16,
   parameter int SYNC = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_spi_clk,
   input  logic          i_spi_mosi,
   output logic          o_spi_miso,
   output logic          o_bus_req,
   output logic          o_bus_we,
   output logic [AW-1:0] o_bus_addr,
   output logic [DW-1:0] o_bus_data,
   input  logic          i_bus_ack,
   input  logic [DW-1:0] i_bus_data
);
   localparam int MW = (AW > DW) ? AW : DW;
   localparam int CW = $clog2(MW + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, WE, DATA, BUS, DONE, RDOUT
   } state_t;

   state_t          state;
   logic [SYNC-1:0] clk_sync;
   logic [SYNC-1:0] mosi_sync;
   logic            clk_prev;
   logic            rise;
   logic            bit_in;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   addr_sr;
   logic [DW-1:0]   rd_sr;

   // Sync flops reset to the idle-high level so releasing reset
   // with spi_clk high never looks like a rising edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         clk_sync  <= '1;
         mosi_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC-2:0], i_spi_clk};
         mosi_sync <= {mosi_sync[SYNC-2:0], i_spi_mosi};
         clk_prev  <= clk_sync[SYNC-1];
      end
   end

   assign rise   = clk_sync[SYNC-1] & ~clk_prev;
   assign bit_in = mosi_sync[SYNC-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         addr_sr    <= '0;
         rd_sr      <= '0;
         o_spi_miso <= 1'b0;
         o_bus_req  <= 1'b0;
         o_bus_we   <= 1'b0;
         o_bus_addr <= '0;
         o_bus_data <= '0;
      end else begin
         unique case (state)
            IDLE: if (rise && !bit_in) begin
               state      <= ADDR;
               cnt        <= '0;
               o_spi_miso <= 1'b1;
            end
            ADDR: if (rise) begin
               addr_sr <= {bit_in, addr_sr[AW-1:1]};
               if (cnt == CW'(AW - 1)) state <= WE;
               else                    cnt   <= cnt + 1'b1;
            end
            WE: if (rise) begin
               o_bus_we   <= bit_in;
               o_bus_addr <= addr_sr;
               cnt        <= '0;
               if (bit_in) begin
                  state <= DATA;
               end else begin
                  state     <= BUS;
                  o_bus_req <= 1'b1;
               end
            end
            // Data shifts straight into the bus register; it only
            // has to hold still once the request is raised.
            DATA: if (rise) begin
               o_bus_data <= {bit_in, o_bus_data[DW-1:1]};
               if (cnt == CW'(DW - 1)) begin
                  state     <= BUS;
                  o_bus_req <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // SPI edges are deliberately not looked at here.
            BUS: if (i_bus_ack) begin
               o_bus_req  <= 1'b0;
               o_spi_miso <= 1'b0;
               rd_sr      <= i_bus_data;
               state      <= DONE;
            end
            // Write: this edge is the end bit. Read: it presents bit0.
            DONE: if (rise) begin
               if (o_bus_we) begin
                  state <= IDLE;
               end else begin
                  o_spi_miso <= rd_sr[0];
                  rd_sr      <= rd_sr >> 1;
                  cnt        <= '0;
                  state      <= RDOUT;
               end
            end
            // DW more edges: the first DW-1 present bits 1..DW-1,
            // the last returns miso to idle.
            RDOUT: if (rise) begin
               if (cnt == CW'(DW - 1)) begin
                  state      <= IDLE;
                  o_spi_miso <= 1'b0;
               end else begin
                  o_spi_miso <= rd_sr[0];
                  rd_sr      <= rd_sr >> 1;
                  cnt        <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_embed_loader.sv
// tb_spi_embed_loader: randomized frames from a host model against a
// bus responder that logs every request; results checked per frame.
module tb_spi_embed_loader;
   localparam int AW   = 24;
   localparam int DW   = 16;
   localparam int HALF = 5;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          spi_clk  = 1'b1;
   logic          spi_mosi = 1'b1;
   logic          bus_ack  = 1'b0;
   logic [DW-1:0] bus_rdata = '0;
   logic          miso;
   logic          bus_req;
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_data;

   spi_embed_loader #(.AW(AW), .DW(DW), .SYNC(2)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_spi_clk  (spi_clk),
      .i_spi_mosi (spi_mosi),
      .o_spi_miso (miso),
      .o_bus_req  (bus_req),
      .o_bus_we   (bus_we),
      .o_bus_addr (bus_addr),
      .o_bus_data (bus_data),
      .i_bus_ack  (bus_ack),
      .i_bus_data (bus_rdata)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bus responder: logs each request, waits ack_delay cycles,
   // pulses ack with rd_val, and checks the request stays put.
   int            ack_delay = 0;
   logic [DW-1:0] rd_val    = '0;
   logic [AW-1:0] q_addr[$];
   logic          q_we[$];
   logic [DW-1:0] q_data[$];
   int            stab_err = 0;
   int            drop_err = 0;
   logic [AW-1:0] cap_addr;
   logic          cap_we;
   logic [DW-1:0] cap_data;

   initial begin
      forever begin
         @(negedge clk);
         if (bus_req === 1'b1) begin
            cap_addr = bus_addr;
            cap_we   = bus_we;
            cap_data = bus_data;
            q_addr.push_back(cap_addr);
            q_we.push_back(cap_we);
            q_data.push_back(cap_data);
            for (int i = 0; i < ack_delay; i++) begin
               @(negedge clk);
               if (bus_req !== 1'b1 || bus_addr !== cap_addr ||
                   bus_we !== cap_we ||
                   (cap_we && bus_data !== cap_data))
                  stab_err++;
            end
            bus_rdata = rd_val;
            bus_ack   = 1'b1;
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = '0;
            if (bus_req !== 1'b0) drop_err++;
         end
      end
   end

   task automatic spi_bit(input logic b);
      spi_mosi = b;
      spi_clk  = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_clk  = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   // Host model: start bit, LSB-first fields, optional extra polling
   // edges while busy, wait for miso low, then end bit or read-out.
   task automatic send_frame(input logic [AW-1:0] a, input logic w,
                             input logic [DW-1:0] d, input int extra,
                             output logic [DW-1:0] rd);
      int n0;
      int t;
      logic [DW-1:0] rx;
      n0 = q_addr.size();
      rx = '0;
      spi_bit(1'b0);
      chk("miso_start", miso, 1);
      for (int i = 0; i < AW; i++) spi_bit(a[i]);
      spi_bit(w);
      if (w) for (int i = 0; i < DW; i++) spi_bit(d[i]);
      for (int i = 0; i < extra; i++) begin
         spi_bit(1'b1);
         chk("miso_hold", miso, 1);
         chk("req_hold", bus_req, 1);
      end
      t = 0;
      while (miso !== 1'b0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("ack_wait", t < 300, 1);
      chk("n_req", q_addr.size() - n0, 1);
      if (q_addr.size() > n0) begin
         chk("addr", q_addr[n0], a);
         chk("we", q_we[n0], w);
         if (w) chk("data", q_data[n0], d);
      end
      spi_bit(1'b1);
      if (!w) begin
         for (int i = 0; i < DW; i++) begin
            rx[i] = miso;
            spi_bit(1'b1);
         end
      end
      repeat (HALF) @(negedge clk);
      chk("miso_end", miso, 0);
      chk("req_end", bus_req, 0);
      chk("n_req_end", q_addr.size() - n0, 1);
      rd = rx;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_miso"}, miso, 0);
      chk({tag, "_req"}, bus_req, 0);
      chk({tag, "_we"}, bus_we, 0);
      chk({tag, "_addr"}, bus_addr, 0);
      chk({tag, "_data"}, bus_data, 0);
   endtask

   initial begin
      logic [DW-1:0] rx;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int n0;

      repeat (4) @(negedge clk);
      chk_reset_outs("rst");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      spi_bit(1'b1);
      spi_bit(1'b1);
      repeat (HALF) @(negedge clk);
      chk("idle_miso", miso, 0);
      chk("idle_noreq", q_addr.size(), 0);

      ack_delay = 3;
      send_frame(24'h800000, 1'b1, 16'h000E, 0, rx);

      for (int k = 0; k < 34; k++) begin
         a = (k == 0)  ? 24'h800000 :
             (k == 33) ? 24'h80003D :
                         24'h800000 + AW'($urandom_range(1, 60));
         d = DW'($urandom);
         ack_delay = $urandom_range(0, 6);
         send_frame(a, 1'b1, d, 0, rx);
      end

      ack_delay = 4;
      rd_val    = 16'h3888;
      send_frame(24'h800021, 1'b0, '0, 0, rx);
      chk("rd_3888", rx, 16'h3888);

      for (int k = 0; k < 4; k++) begin
         a = AW'($urandom);
         rd_val = DW'($urandom);
         ack_delay = $urandom_range(0, 8);
         send_frame(a, 1'b0, '0, 0, rx);
         chk("rd_rand", rx, rd_val);
      end

      ack_delay = 50;
      send_frame(24'h800040, 1'b1, 16'hA5C3, 4, rx);
      rd_val = 16'h5A0F;
      send_frame(24'h800041, 1'b0, '0, 4, rx);
      chk("rd_slow", rx, 16'h5A0F);

      ack_delay = 2;
      n0 = q_addr.size();
      spi_bit(1'b0);
      for (int i = 0; i < 10; i++) spi_bit(1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outs("abort");
      spi_bit(1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_noreq", q_addr.size() - n0, 0);
      chk("abort_miso", miso, 0);
      send_frame(24'h812345, 1'b1, 16'hBEEF, 0, rx);
      send_frame(24'h800042, 1'b1, 16'h1234, 0, rx);

      for (int k = 0; k < 4; k++) begin
         a = AW'($urandom);
         d = DW'($urandom);
         ack_delay = $urandom_range(0, 5);
         send_frame(a, 1'b1, d, 0, rx);
      end

      chk("stable", stab_err, 0);
      chk("drop", drop_err, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
